// File: rtl/text_ram_port_arbiter_if.sv
// Bundle of the two requester ports and the text RAM port around text_ram_port_arbiter.
// The arbiter uses the slave modport; requesters and the RAM sit on the master side.
interface text_ram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_lock;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_lock;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
        input  r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
        input  ram_q,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output ram_address, ram_data, ram_wren
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
        output r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
        output ram_q,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/text_ram_port_arbiter.sv
// Round-robin arbiter sharing one text RAM port between the VT100 parser (r0) and the
// scroll/clear engine (r1), with bounded burst locking and tagged read-data return.
module text_ram_port_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 2,
    parameter int LOCK_MAX = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    text_ram_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

    typedef enum logic [1:0] {
        ST_RR   = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_winner_q, last_winner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [RD_LAT-1:0] tag_valid_q, tag_valid_d;
    logic [RD_LAT-1:0] tag_id_q, tag_id_d;

    logic              raw0_s, raw1_s;
    logic              gnt0_s, gnt1_s, gnt_any_s;
    logic              win_s, win_we_s, win_lock_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_data_s;
    logic              rvalid0_s, rvalid1_s;

    // Raw grant decision from the current ownership state and the request lines
    always_comb begin
        raw0_s = 1'b0;
        raw1_s = 1'b0;
        case (state_q)
            ST_RR: begin
                if (bus.r0_req && bus.r1_req) begin
                    raw0_s = last_winner_q;
                    raw1_s = !last_winner_q;
                end else begin
                    raw0_s = bus.r0_req;
                    raw1_s = bus.r1_req;
                end
            end
            ST_OWN0: begin
                raw0_s = bus.r0_req;
                raw1_s = !bus.r0_req && bus.r1_req;
            end
            ST_OWN1: begin
                raw1_s = bus.r1_req;
                raw0_s = !bus.r1_req && bus.r0_req;
            end
            default: begin
                raw0_s = 1'b0;
                raw1_s = 1'b0;
            end
        endcase
    end

    assign gnt0_s     = rst & raw0_s;
    assign gnt1_s     = rst & raw1_s;
    assign gnt_any_s  = gnt0_s | gnt1_s;
    assign win_s      = gnt1_s;
    assign win_we_s   = win_s ? bus.r1_we    : bus.r0_we;
    assign win_lock_s = win_s ? bus.r1_lock  : bus.r0_lock;
    assign win_addr_s = win_s ? bus.r1_addr  : bus.r0_addr;
    assign win_data_s = win_s ? bus.r1_wdata : bus.r0_wdata;

    // Ownership FSM; the lock counter also runs on idle cycles so a dead lock still expires
    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        cnt_d         = cnt_q;
        case (state_q)
            ST_RR: begin
                if (gnt_any_s) begin
                    last_winner_d = win_s;
                    if (win_lock_s && (LOCK_MAX > 1)) begin
                        state_d = win_s ? ST_OWN1 : ST_OWN0;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_OWN0: begin
                if ((gnt0_s && !bus.r0_lock) || (cnt_q >= CNT_LAST)) begin
                    state_d       = ST_RR;
                    last_winner_d = 1'b0;
                    cnt_d         = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_OWN1: begin
                if ((gnt1_s && !bus.r1_lock) || (cnt_q >= CNT_LAST)) begin
                    state_d       = ST_RR;
                    last_winner_d = 1'b1;
                    cnt_d         = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RR;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // RAM-side hold registers and the {valid,id} read tag pipeline
    always_comb begin
        addr_d      = gnt_any_s ? win_addr_s : addr_q;
        data_d      = gnt_any_s ? win_data_s : data_q;
        tag_valid_d = tag_valid_q;
        tag_id_d    = tag_id_q;
        tag_valid_d[0] = gnt_any_s & !win_we_s;
        tag_id_d[0]    = win_s;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RR;
            last_winner_q <= 1'b1;
            cnt_q         <= CNT_ZERO;
            addr_q        <= {ADDR_W{1'b0}};
            data_q        <= {DATA_W{1'b0}};
            tag_valid_q   <= {RD_LAT{1'b0}};
            tag_id_q      <= {RD_LAT{1'b0}};
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            tag_valid_q   <= tag_valid_d;
            tag_id_q      <= tag_id_d;
        end
    end

    assign rvalid0_s = tag_valid_q[RD_LAT-1] & !tag_id_q[RD_LAT-1];
    assign rvalid1_s = tag_valid_q[RD_LAT-1] &  tag_id_q[RD_LAT-1];

    assign bus.r0_gnt      = gnt0_s;
    assign bus.r1_gnt      = gnt1_s;
    assign bus.r0_rvalid   = rvalid0_s;
    assign bus.r1_rvalid   = rvalid1_s;
    assign bus.r0_rdata    = rvalid0_s ? bus.ram_q : {DATA_W{1'b0}};
    assign bus.r1_rdata    = rvalid1_s ? bus.ram_q : {DATA_W{1'b0}};
    assign bus.ram_address = addr_d;
    assign bus.ram_data    = data_d;
    assign bus.ram_wren    = gnt_any_s & win_we_s;

endmodule

// File: tb/tb_text_ram_port_arbiter.sv
// Directed bench for text_ram_port_arbiter: a default instance on a write-first RAM
// model with 2-cycle read latency, and a LOCK_MAX=4 instance for lock expiry.
module tb_text_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    text_ram_port_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus_a ();
    text_ram_port_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus_b ();

    text_ram_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(2), .LOCK_MAX(64)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    text_ram_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(2), .LOCK_MAX(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Unwritten words read back as a recognisable address-derived pattern
    logic [31:0]   mem [0:2047];
    logic [2047:0] written;
    logic [31:0]   rd1;
    logic [31:0]   ramq;

    function automatic logic [31:0] dflt(input logic [10:0] a);
        return {16'hC0DE, 5'd0, a};
    endfunction

    function automatic logic [31:0] rd_word(input logic [10:0] a);
        return written[a] ? mem[a] : dflt(a);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            written = '0;
        end else if (bus_a.ram_wren) begin
            mem[bus_a.ram_address]     = bus_a.ram_data;
            written[bus_a.ram_address] = 1'b1;
        end
        rd1  <= rd_word(bus_a.ram_address);
        ramq <= rd1;
    end

    assign bus_a.ram_q = ramq;
    assign bus_b.ram_q = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    logic       w [8];
    logic [10:0] wa [8];
    logic [10:0] n0;
    logic [10:0] n1;

    initial begin
        rst = 1'b0;
        bus_a.r0_req = 1'b0; bus_a.r0_we = 1'b0; bus_a.r0_addr = 11'h0; bus_a.r0_wdata = 32'h0; bus_a.r0_lock = 1'b0;
        bus_a.r1_req = 1'b0; bus_a.r1_we = 1'b0; bus_a.r1_addr = 11'h0; bus_a.r1_wdata = 32'h0; bus_a.r1_lock = 1'b0;
        bus_b.r0_req = 1'b0; bus_b.r0_we = 1'b0; bus_b.r0_addr = 11'h0; bus_b.r0_wdata = 32'h0; bus_b.r0_lock = 1'b0;
        bus_b.r1_req = 1'b0; bus_b.r1_we = 1'b0; bus_b.r1_addr = 11'h0; bus_b.r1_wdata = 32'h0; bus_b.r1_lock = 1'b0;

        // Reset held three cycles with r0 requesting
        bus_a.r0_req  = 1'b1;
        bus_a.r0_addr = 11'h005;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("rst_gnt0",   64'(bus_a.r0_gnt),      64'(1'b0));
            chk("rst_gnt1",   64'(bus_a.r1_gnt),      64'(1'b0));
            chk("rst_wren",   64'(bus_a.ram_wren),    64'(1'b0));
            chk("rst_addr",   64'(bus_a.ram_address), 64'(11'h000));
            chk("rst_rvalid", 64'(bus_a.r0_rvalid),   64'(1'b0));
        end
        tick(); rst = 1'b1;
        samp();
        chk("first_gnt0", 64'(bus_a.r0_gnt),      64'(1'b1));
        chk("first_gnt1", 64'(bus_a.r1_gnt),      64'(1'b0));
        chk("first_addr", 64'(bus_a.ram_address), 64'(11'h005));
        tick(); bus_a.r0_req = 1'b0;
        samp();
        chk("idle_gnt0",   64'(bus_a.r0_gnt),      64'(1'b0));
        chk("idle_hold",   64'(bus_a.ram_address), 64'(11'h005));
        chk("early_rv0",   64'(bus_a.r0_rvalid),   64'(1'b0));
        tick();
        samp();
        chk("first_rv0",   64'(bus_a.r0_rvalid),   64'(1'b1));
        chk("first_rd0",   64'(bus_a.r0_rdata),    64'(dflt(11'h005)));
        chk("first_rv1",   64'(bus_a.r1_rvalid),   64'(1'b0));
        tick();
        samp();
        chk("pulse_rv0",   64'(bus_a.r0_rvalid),   64'(1'b0));
        chk("pulse_rd0",   64'(bus_a.r0_rdata),    64'(32'h0));

        // Contention: both read continuously; r0 won last, so r1 takes the first tie
        n0 = 11'h010;
        n1 = 11'h020;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 6) begin
                bus_a.r0_req = 1'b1; bus_a.r0_we = 1'b0; bus_a.r0_addr = n0;
                bus_a.r1_req = 1'b1; bus_a.r1_we = 1'b0; bus_a.r1_addr = n1;
            end else begin
                bus_a.r0_req = 1'b0;
                bus_a.r1_req = 1'b0;
            end
            samp();
            if (k < 6) begin
                w[k]  = ~k[0];
                wa[k] = w[k] ? n1 : n0;
                chk("rr_gnt0", 64'(bus_a.r0_gnt),      64'(!w[k]));
                chk("rr_gnt1", 64'(bus_a.r1_gnt),      64'(w[k]));
                chk("rr_addr", 64'(bus_a.ram_address), 64'(wa[k]));
                if (w[k]) n1 = n1 + 11'd1;
                else      n0 = n0 + 11'd1;
            end
            if (k >= 2) begin
                chk("rr_rv0", 64'(bus_a.r0_rvalid), 64'(!w[k-2]));
                chk("rr_rv1", 64'(bus_a.r1_rvalid), 64'(w[k-2]));
                chk("rr_rdata", 64'(w[k-2] ? bus_a.r1_rdata : bus_a.r0_rdata), 64'(dflt(wa[k-2])));
            end
        end

        // Lock burst: r1 writes 0..9 holding the lock, r0 waits throughout
        for (int i = 0; i < 10; i++) begin
            tick();
            bus_a.r0_req = 1'b1; bus_a.r0_we = 1'b0; bus_a.r0_addr = 11'h030;
            bus_a.r1_req = 1'b1; bus_a.r1_we = 1'b1; bus_a.r1_addr = 11'(i);
            bus_a.r1_wdata = 32'h5000_0000 + 32'(i);
            bus_a.r1_lock  = (i < 9);
            samp();
            chk("burst_gnt1", 64'(bus_a.r1_gnt),      64'(1'b1));
            chk("burst_gnt0", 64'(bus_a.r0_gnt),      64'(1'b0));
            chk("burst_wren", 64'(bus_a.ram_wren),    64'(1'b1));
            chk("burst_addr", 64'(bus_a.ram_address), 64'(i));
            chk("burst_data", 64'(bus_a.ram_data),    64'(32'h5000_0000 + 32'(i)));
            chk("burst_rv1",  64'(bus_a.r1_rvalid),   64'(1'b0));
        end
        tick(); bus_a.r1_req = 1'b0; bus_a.r1_we = 1'b0; bus_a.r1_lock = 1'b0;
        samp();
        chk("after_gnt0", 64'(bus_a.r0_gnt),      64'(1'b1));
        chk("after_gnt1", 64'(bus_a.r1_gnt),      64'(1'b0));
        chk("after_wren", 64'(bus_a.ram_wren),    64'(1'b0));
        chk("after_addr", 64'(bus_a.ram_address), 64'(11'h030));
        tick(); bus_a.r0_req = 1'b0; bus_a.r1_req = 1'b1; bus_a.r1_addr = 11'h003;
        samp();
        chk("rb_gnt1", 64'(bus_a.r1_gnt), 64'(1'b1));
        tick(); bus_a.r1_req = 1'b0;
        samp();
        chk("after_rv0", 64'(bus_a.r0_rvalid), 64'(1'b1));
        chk("after_rd0", 64'(bus_a.r0_rdata),  64'(dflt(11'h030)));
        tick();
        samp();
        chk("rb_rv1", 64'(bus_a.r1_rvalid), 64'(1'b1));
        chk("rb_rd1", 64'(bus_a.r1_rdata),  64'(32'h5000_0003));

        // Write then immediate read of the same cell
        tick(); bus_a.r0_req = 1'b1; bus_a.r0_we = 1'b1; bus_a.r0_addr = 11'h7CF; bus_a.r0_wdata = 32'hDEAD_BEEF;
        samp();
        chk("wr_gnt0", 64'(bus_a.r0_gnt),   64'(1'b1));
        chk("wr_wren", 64'(bus_a.ram_wren), 64'(1'b1));
        chk("wr_data", 64'(bus_a.ram_data), 64'(32'hDEAD_BEEF));
        tick(); bus_a.r0_we = 1'b0;
        samp();
        chk("rd_gnt0", 64'(bus_a.r0_gnt),   64'(1'b1));
        chk("rd_wren", 64'(bus_a.ram_wren), 64'(1'b0));
        tick(); bus_a.r0_req = 1'b0;
        samp();
        chk("wr_no_rv", 64'(bus_a.r0_rvalid), 64'(1'b0));
        tick();
        samp();
        chk("wr_rd_rv", 64'(bus_a.r0_rvalid), 64'(1'b1));
        chk("wr_rd_q",  64'(bus_a.r0_rdata),  64'(32'hDEAD_BEEF));

        // Reset one cycle after a granted read flushes it
        tick(); bus_a.r0_req = 1'b1; bus_a.r0_addr = 11'h040;
        samp();
        chk("mr_gnt0", 64'(bus_a.r0_gnt), 64'(1'b1));
        tick(); bus_a.r0_req = 1'b0; rst = 1'b0;
        samp();
        chk("mr_rv0_a",  64'(bus_a.r0_rvalid), 64'(1'b0));
        chk("mr_gnt_rs", 64'(bus_a.r0_gnt),    64'(1'b0));
        tick(); rst = 1'b1;
        samp();
        chk("mr_rv0_b", 64'(bus_a.r0_rvalid), 64'(1'b0));
        tick();
        samp();
        chk("mr_rv0_c", 64'(bus_a.r0_rvalid), 64'(1'b0));
        tick();
        samp();
        chk("mr_rv0_d", 64'(bus_a.r0_rvalid), 64'(1'b0));
        chk("mr_rv1_d", 64'(bus_a.r1_rvalid), 64'(1'b0));

        // Lock expiry on the LOCK_MAX=4 instance, r1_lock stuck high
        tick(); bus_b.r1_req = 1'b1; bus_b.r1_lock = 1'b1;
        samp();
        chk("to_t0_gnt1", 64'(bus_b.r1_gnt), 64'(1'b1));
        chk("to_t0_gnt0", 64'(bus_b.r0_gnt), 64'(1'b0));
        for (int i = 1; i < 4; i++) begin
            tick(); bus_b.r0_req = 1'b1;
            samp();
            chk("to_own_gnt1", 64'(bus_b.r1_gnt), 64'(1'b1));
            chk("to_own_gnt0", 64'(bus_b.r0_gnt), 64'(1'b0));
        end
        tick();
        samp();
        chk("to_exp_gnt0", 64'(bus_b.r0_gnt), 64'(1'b1));
        chk("to_exp_gnt1", 64'(bus_b.r1_gnt), 64'(1'b0));
        tick();
        samp();
        chk("to_back_gnt1", 64'(bus_b.r1_gnt), 64'(1'b1));
        chk("to_back_gnt0", 64'(bus_b.r0_gnt), 64'(1'b0));
        // Idle lock cycles still count toward expiry
        for (int i = 0; i < 3; i++) begin
            tick(); bus_b.r1_req = 1'b0;
            samp();
            chk("idle_own_gnt0", 64'(bus_b.r0_gnt), 64'(1'b1));
            chk("idle_own_gnt1", 64'(bus_b.r1_gnt), 64'(1'b0));
        end
        tick(); bus_b.r1_req = 1'b1;
        samp();
        chk("idle_exp_gnt0", 64'(bus_b.r0_gnt), 64'(1'b1));
        chk("idle_exp_gnt1", 64'(bus_b.r1_gnt), 64'(1'b0));
        tick();
        samp();
        chk("idle_rr_gnt1", 64'(bus_b.r1_gnt), 64'(1'b1));
        chk("idle_rr_gnt0", 64'(bus_b.r0_gnt), 64'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
